mem_tester_master: RTL and testbench

MEM_TESTER_MASTER -- requirements
Module: mem_tester_master

---
 rtl/mem_tester_pkg.sv | 9 +
 rtl/mem_tester_pattern_gen.sv | 33 +++
 rtl/mem_tester_master.sv | 123 ++++++++++++
 tb/tb_mem_tester_master.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_tester_pkg.sv
// mem_tester_pkg: shared FSM state type and pattern constants for the memory tester.
// Build option: define MEM_TESTER_LFSR_EN to generate the LFSR data pattern instead of the address XOR pattern.
package mem_tester_pkg;
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as a mask over bits [15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [63:0] PAT_XOR = {32{2'b10}};
endpackage

// File: rtl/mem_tester_pattern_gen.sv
// mem_tester_pattern_gen: produces the data pattern for one word index.
// Ports: clk/reset (async, active-high); reload restarts the sequence; step advances it;
// addr is the word address (start_addr + index); pattern is the expected data word.
// Build option: MEM_TESTER_LFSR_EN selects a 16-bit Fibonacci LFSR sequence; otherwise pattern = addr XOR 1010...
module mem_tester_pattern_gen
    import mem_tester_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reload,
    input  logic              step,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pattern
);
`ifdef MEM_TESTER_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic unused_addr;
    assign unused_addr = ^addr;
    assign lfsr_d = reload ? LFSR_SEED : step ? {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else lfsr_q <= lfsr_d;
    end
    assign pattern = DATA_W'(lfsr_q);
`else
    logic unused_ctl;
    assign unused_ctl = ^{clk, reset, reload, step};
    assign pattern = DATA_W'(addr) ^ PAT_XOR[DATA_W-1:0];
`endif
endmodule

// File: rtl/mem_tester_master.sv
// mem_tester_master: Avalon-MM master that writes a pattern to WORD_COUNT words, reads them back and counts mismatches.
// Ports: clk, reset (async, active-high); start/start_addr launch a run; busy/done/pass/error_count/first_fail_addr report it;
// avm_* is the Avalon-MM master interface (pipelined reads, up to MAX_OUTSTANDING in flight).
// Build option: MEM_TESTER_LFSR_EN (handled in mem_tester_pattern_gen) selects the LFSR data pattern.
module mem_tester_master
    import mem_tester_pkg::*;
#(
    parameter int ADDR_W          = 25,
    parameter int DATA_W          = 16,
    parameter int WORD_COUNT      = 1024,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       error_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              avm_read,
    output logic              avm_write,
    input  logic              avm_waitrequest,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_readdatavalid,
    input  logic [DATA_W-1:0] avm_readdata
);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(WORD_COUNT - 1);
    localparam logic [3:0]      MAX_OUT  = 4'(MAX_OUTSTANDING);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, rsp_q, rsp_d, ffa_q, ffa_d, wr_addr, chk_addr;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [3:0]        out_q, out_d;
    logic [15:0]       err_q, err_d;
    logic              start_acc, wr_acc, rd_acc, rsp_vld, last, mismatch;
    logic [DATA_W-1:0] wr_pat, chk_pat;

    // Address arithmetic wraps naturally in ADDR_W bits.
    assign wr_addr   = base_q + idx_q[ADDR_W-1:0];
    assign chk_addr  = base_q + rsp_q;
    assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
    assign avm_write = state_q == S_WRITE;
    assign avm_read  = state_q == S_READ && out_q < MAX_OUT;
    assign wr_acc    = avm_write && !avm_waitrequest;
    assign rd_acc    = avm_read && !avm_waitrequest;
    // Responses only count while reads can be pending; strays never underflow the counter.
    assign rsp_vld   = avm_readdatavalid && (state_q == S_READ || state_q == S_DRAIN) && out_q != '0;
    assign last      = idx_q == LAST_IDX;
    assign mismatch  = rsp_vld && avm_readdata != chk_pat;

    assign busy            = state_q == S_WRITE || state_q == S_READ || state_q == S_DRAIN;
    assign done            = state_q == S_DONE;
    assign pass            = done && err_q == '0;
    assign error_count     = err_q;
    assign first_fail_addr = ffa_q;
    assign avm_address     = (state_q == S_WRITE || state_q == S_READ) ? wr_addr : '0;
    assign avm_writedata   = avm_write ? wr_pat : '0;
    assign avm_byteenable  = 4'hF;

    mem_tester_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pat (
        .clk(clk), .reset(reset), .reload(start_acc), .step(wr_acc), .addr(wr_addr), .pattern(wr_pat)
    );
    mem_tester_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk_pat (
        .clk(clk), .reset(reset), .reload(start_acc), .step(rsp_vld), .addr(chk_addr), .pattern(chk_pat)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        rsp_d   = rsp_q;
        out_d   = out_q + {3'b0, rd_acc} - {3'b0, rsp_vld};
        err_d   = err_q;
        ffa_d   = ffa_q;
        if (start_acc) begin
            state_d = S_WRITE;
            base_d  = start_addr;
            idx_d   = '0;
            rsp_d   = '0;
            out_d   = '0;
            err_d   = '0;
            ffa_d   = '0;
        end
        if (wr_acc) begin
            idx_d   = last ? '0 : idx_q + (ADDR_W+1)'(1);
            state_d = last ? S_READ : S_WRITE;
        end
        if (rd_acc) begin
            idx_d   = last ? '0 : idx_q + (ADDR_W+1)'(1);
            state_d = last ? S_DRAIN : S_READ;
        end
        if (state_q == S_DRAIN && out_q == '0) state_d = S_DONE;
        if (rsp_vld) rsp_d = rsp_q + ADDR_W'(1);
        if (mismatch) begin
            err_d = err_q == 16'hFFFF ? err_q : err_q + 16'd1;
            ffa_d = err_q == '0 ? chk_addr : ffa_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            rsp_q   <= '0;
            out_q   <= '0;
            err_q   <= '0;
            ffa_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            rsp_q   <= rsp_d;
            out_q   <= out_d;
            err_q   <= err_d;
            ffa_q   <= ffa_d;
        end
    end
endmodule

// File: tb/tb_mem_tester_master.sv
// tb_mem_tester_master: directed bench with an Avalon-MM memory model (random stall, programmable read latency, bit-flip fault).
module tb_mem_tester_master;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int WC = 16;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start, busy, done, pass, avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
    logic [AW-1:0] start_addr, first_fail_addr, avm_address;
    logic [15:0]   error_count;
    logic [3:0]    avm_byteenable;
    logic [DW-1:0] avm_writedata, avm_readdata;

    mem_tester_master #(.ADDR_W(AW), .DATA_W(DW), .WORD_COUNT(WC), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count), .first_fail_addr(first_fail_addr),
        .avm_read(avm_read), .avm_write(avm_write), .avm_waitrequest(avm_waitrequest),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_readdatavalid(avm_readdatavalid), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } rsp_t;

    int            checks = 0;
    int            errors = 0;
    int            wait_pct, lat, cyc, wr_cnt, rd_cnt, rsp_cnt, tb_out, max_out;
    bit            flip_en, prev_stall, prev_wr, prev_rd;
    logic [AW-1:0] exp_base, prev_addr, wr_first, wr4_addr, a_tmp;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] mem [logic [AW-1:0]];
    rsp_t          pend [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_pat(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'hAAAA;
    endfunction

    // Memory slave: decides stall and drives responses mid-cycle so the DUT samples them on the next rising edge.
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_stall = 0;
                tb_out = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_cmd", {30'b0, avm_write, avm_read}, {30'b0, prev_wr, prev_rd});
                    check("hold_addr", avm_address, prev_addr);
                    if (prev_wr) check("hold_data", avm_writedata, prev_data);
                end
                if (avm_read && avm_write) check("rw_excl", 1, 0);
                avm_waitrequest = $urandom_range(99) < wait_pct;
                if (avm_write && !avm_waitrequest) begin
                    a_tmp = exp_base + AW'(wr_cnt);
                    check("wr_addr", avm_address, a_tmp);
                    check("wr_data", avm_writedata, exp_pat(a_tmp));
                    mem[avm_address] = avm_writedata;
                    if (wr_cnt == 0) wr_first = avm_address;
                    if (wr_cnt == 4) wr4_addr = avm_address;
                    wr_cnt++;
                end
                if (avm_read && !avm_waitrequest) begin
                    a_tmp = exp_base + AW'(rd_cnt);
                    check("rd_addr", avm_address, a_tmp);
                    pend.push_back('{mem[avm_address] ^ DW'(flip_en && avm_address == 5), cyc + lat});
                    rd_cnt++;
                    tb_out++;
                    if (tb_out > max_out) max_out = tb_out;
                    check("outstanding_le_max", tb_out <= MO, 1);
                end
                prev_stall = (avm_read || avm_write) && avm_waitrequest;
                prev_wr = avm_write;
                prev_rd = avm_read;
                prev_addr = avm_address;
                prev_data = avm_writedata;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                avm_readdatavalid = 1;
                avm_readdata = pend[0].d;
                void'(pend.pop_front());
                rsp_cnt++;
                if (tb_out > 0) tb_out--;
            end else begin
                avm_readdatavalid = 0;
                avm_readdata = '0;
            end
        end
    end

    task automatic launch(input logic [AW-1:0] a, input int wp, input int l, input bit fl);
        @(negedge clk);
        wait_pct = wp;
        lat = l;
        flip_en = fl;
        exp_base = a;
        wr_cnt = 0;
        rd_cnt = 0;
        rsp_cnt = 0;
        max_out = 0;
        start = 1;
        start_addr = a;
        @(negedge clk);
        start = 0;
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
    endtask

    task automatic run(input logic [AW-1:0] a, input int wp, input int l, input bit fl, input bit poke);
        launch(a, wp, l, fl);
        for (int k = 0; k < 3000 && !done; k++) begin
            start = poke && k == 3;
            start_addr = (poke && k == 3) ? AW'(100) : a;
            @(negedge clk);
        end
        start = 0;
        check("done_within_budget", done, 1);
        check("busy_at_done", busy, 0);
        check("writes", wr_cnt, WC);
        check("reads", rd_cnt, WC);
        check("responses", rsp_cnt, WC);
    endtask

    initial begin
        start = 0;
        start_addr = '0;
        avm_waitrequest = 0;
        avm_readdatavalid = 0;
        avm_readdata = '0;
        wait_pct = 0;
        lat = 1;
        flip_en = 0;
        exp_base = '0;
        #2 reset = 1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_cmd", {avm_read, avm_write}, 0);
        check("rst_addr", avm_address, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_errcnt", error_count, 0);
        check("rst_ffa", first_fail_addr, 0);
        check("byteenable", avm_byteenable, 4'hF);
        repeat (3) @(negedge clk);
        reset = 0;

        run(0, 0, 1, 0, 1);
        check("basic_pass", pass, 1);
        check("basic_errcnt", error_count, 0);

        run(0, 50, 1, 0, 0);
        check("stall_pass", pass, 1);

        run(0, 0, 1, 1, 0);
        check("flip_pass", pass, 0);
        check("flip_errcnt", error_count, 1);
        check("flip_ffa", first_fail_addr, 5);

        run(0, 0, 10, 0, 0);
        check("lat_pass", pass, 1);
        check("lat_max_out", max_out, MO);

        run(AW'(33554428), 0, 1, 0, 0);
        check("wrap_pass", pass, 1);
        check("wrap_first", wr_first, 33554428);
        check("wrap_to_zero", wr4_addr, 0);

        launch(0, 0, 10, 0);
        for (int k = 0; k < 500 && rd_cnt < 6; k++) @(negedge clk);
        check("reached_read", rd_cnt >= 6, 1);
        #2 reset = 1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_read", avm_read, 0);
        check("mid_rst_write", avm_write, 0);
        check("mid_rst_addr", avm_address, 0);
        check("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (30) @(negedge clk);
        check("idle_after_late_rsp", busy, 0);
        run(0, 0, 1, 0, 0);
        check("post_rst_pass", pass, 1);
        check("post_rst_errcnt", error_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
